// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use/branch hazard control and mult/div sequencing for the 5-stage core
// Hazard outputs are combinational so they act in the cycle the hazard is seen.
module pipe_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             id_muldiv_i,
  input  logic             id_reads_hilo_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             ex_branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             muldiv_start_o,
  output logic             muldiv_busy_o,
  output logic             muldiv_done_o,
  output logic             state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic       LP_RUN    = 1'b0;
  localparam logic       LP_MDBUSY = 1'b1;
  localparam logic [7:0] LP_LOAD   = 8'(MULDIV_CYCLES - 1);

  logic             r_state;
  logic             w_state_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_load_use;
  logic             w_hilo_hz;
  logic             w_stall;
  logic             w_start;

  assign w_load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
  // A second mult/div waits behind the busy window exactly like an mfhi/mflo.
  assign w_hilo_hz  = (r_state == LP_MDBUSY) && (id_reads_hilo_i || id_muldiv_i);
  assign w_stall    = (w_load_use || w_hilo_hz) && !ex_branch_taken_i;
  assign w_start    = (r_state == LP_RUN) && id_muldiv_i && !w_stall && !ex_branch_taken_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= LP_RUN;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      LP_RUN: begin
        if (w_start) begin
          w_state_nxt = LP_MDBUSY;
          w_cnt_nxt   = LP_LOAD;
        end
      end
      default: begin
        if (r_cnt != 8'd0) w_cnt_nxt   = r_cnt - 8'd1;
        else               w_state_nxt = LP_RUN;
      end
    endcase
  end

  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    muldiv_start_o = 1'b0;
    muldiv_busy_o  = 1'b0;
    muldiv_done_o  = 1'b0;
    if (!rst_i) begin
      if (ex_branch_taken_i) begin
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end else if (w_stall) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end
      muldiv_start_o = w_start;
      muldiv_busy_o  = (r_state == LP_MDBUSY);
      muldiv_done_o  = (r_state == LP_MDBUSY) && (r_cnt == 8'd0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign state_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;

endmodule
